apb_mem: RTL and testbench
==========================

# apb_mem

Parametrised APB slave memory, successor to the 8-bit single-port RAM. Byte-lane write strobes, a configurable number of wait states, an address-range error response and an asynchronous reset on all interface state. It sits on the APB bus beside the I2C master as general-purpose scratch and buffer storage, and is addressed in words.

## Interface
- `DATA_W`, default 8: data width; a multiple of 8, range 8..64.
- `ADDR_W`, default 8: `PADDR` width, word address.
- `DEPTH`, default 256: number of words; `DEPTH` ≤ 2**`ADDR_W`.
- `WAIT`, default 0: wait states inserted in the access phase; range 0..15.
- `PCLK` in 1: single clock; all logic on the rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in `ADDR_W`: word address.
- `PWDATA` in `DATA_W`: write data.
- `PSTRB` in `DATA_W`/8: byte-lane write enables; ignored on reads.
- `PRDATA` out `DATA_W`: read data, registered.
- `PREADY` out 1: transfer completes in this access cycle, registered.
- `PSLVERR` out 1: error response, registered; meaningful only while `PREADY`=1.

## Operation
- FSM states are `IDLE`, `WAIT` and `READY`; the wait counter `cnt` is 4 bits wide.
- Setup edge: `PSEL`=1, `PENABLE`=0 sampled while in `IDLE`.
  - Latch `PADDR`, `PWRITE`, `PWDATA` and `PSTRB`.
  - `err` = (`PADDR` ≥ `DEPTH`).
  - Good read: `PRDATA` <= mem[`PADDR`]. Any other case: `PRDATA` <= 0.
  - `WAIT`=0: go to `READY` and set `PREADY`<=1, `PSLVERR`<=`err`.
  - `WAIT`>0: go to `WAIT` and set `cnt`<=`WAIT`.
- `WAIT` state: each edge with `PSEL`=1 does `cnt`<=`cnt`-1. When `cnt`=1, go to `READY` and set `PREADY`<=1, `PSLVERR`<=`err`.
- `READY` state, completion edge (`PSEL` & `PENABLE` & `PREADY`):
  - Write with `err`=0: each lane i with `PSTRB`[i]=1 takes the latched `PWDATA` byte i. Other lanes are unchanged.
  - Then `PREADY`<=0, `PSLVERR`<=0, go to `IDLE`.
- Write with `PSTRB`=0: completes normally with `PSLVERR`=0 and changes no memory.
- Erroring write: memory unchanged. Erroring read: `PRDATA`=0.
- `PRDATA` holds its value from one setup edge to the next. Write transfers clear it to 0.
- `PSEL` dropping in `WAIT` or `READY` is a protocol violation. The block aborts to `IDLE` with no write and `PREADY`=`PSLVERR`=0.
- `PENABLE`=1 sampled in `IDLE` with no preceding setup edge is ignored and is not a transfer.
- Reset, asynchronous and valid at any point including mid-transfer:
  - Outputs: `PRDATA`=0, `PREADY`=0, `PSLVERR`=0.
  - Internal: state=`IDLE`, `cnt`=0.
  - The transfer in flight is dropped and no write occurs.
  - Memory contents are not reset.

## Timing
- A transfer takes `WAIT` + 2 cycles: 1 setup cycle plus `WAIT`+1 access cycles. `PREADY` is 0 for the first `WAIT` access cycles and 1 in the last.
- Read data is valid in the completion cycle, i.e. the same cycle `PREADY`=1.
- A write becomes visible to a read whose setup edge follows the write's completion edge.
- Back-to-back transfers: the setup cycle immediately after completion is accepted. Sustained throughput is 1 transfer per `WAIT`+2 cycles.
- The block never asserts `PREADY` outside `READY`.

## Structure
- Shared package `apb_mem_pkg` holds:
  - The state encoding (`IDLE`=2'd0, `WAIT`=2'd1, `READY`=2'd2).
  - A `STRB_W` = `DATA_W`/8 helper.
  - The `cnt` width constant (4).
- Sub-module `mem_sp_be`: single-port synchronous RAM, parameters `DATA_W`/`ADDR_W`/`DEPTH`.
  - Ports: `clk`, `ce`, `wren`, `rden`, `be`, `addr`, `wr_data`, `rd_data`.
  - Read has priority over write when both are set; 1-cycle read latency.
  - No reset on the array.
- Top level: APB FSM, wait counter, range check and output registers, driving `mem_sp_be`.

## Test plan
- `WAIT`=0, `DATA_W`=32:
  - Write 0xDEADBEEF to addr 5 with `PSTRB`=4'hF, then read addr 5 → `PREADY`=1 in the first access cycle, `PRDATA`=0xDEADBEEF, `PSLVERR`=0.
  - Write 0x000000AA to addr 5 with `PSTRB`=4'b0001, then read → `PRDATA`=0xDEADBEAA.
- `WAIT`=3: any read → `PREADY` low for exactly 3 access cycles, high in the 4th. Back-to-back read/write/read sequences complete at one transfer per 5 cycles.
- `DEPTH`=200, `ADDR_W`=8:
  - Read addr 200 → `PSLVERR`=1, `PRDATA`=0.
  - Write addr 255 → `PSLVERR`=1, and a read of addr 55 returns its prior value (no alias).
- `WAIT`=5: assert `PRESETn`=0 during the 2nd wait cycle of a write to addr 7 (old value 0x11, new data 0x22) → outputs 0 immediately. After release, a read of addr 7 returns 0x11.
- Abort: drop `PSEL` mid-`WAIT` on a write → no memory change, `PREADY`=0, and the next normal transfer completes correctly.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// rtl/apb_mem_pkg.sv - shared state encoding and width helpers for apb_mem
package apb_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_sp_be.sv
// rtl/mem_sp_be.sv - single-port synchronous RAM with byte enables, read has priority
module mem_sp_be
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                        i_clk,
  input  logic                        i_ce,
  input  logic                        i_wren,
  input  logic                        i_rden,
  input  logic [strb_w(DATA_W)-1:0]   i_be,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  output logic [DATA_W-1:0]           o_rd_data
);

  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // The array is deliberately not reset; contents survive a bus reset.
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      if (i_rden) begin
        r_rd_data <= r_mem[i_addr];
      end else if (i_wren) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (i_be[i]) begin
            r_mem[i_addr][i*8 +: 8] <= i_wr_data[i*8 +: 8];
          end
        end
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_mem.sv
// rtl/apb_mem.sv - APB slave scratch memory with byte strobes, wait states and range error
module apb_mem
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 0
) (
  input  logic                        i_pclk,
  input  logic                        i_presetn,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [ADDR_W-1:0]           i_paddr,
  input  logic [DATA_W-1:0]           i_pwdata,
  input  logic [strb_w(DATA_W)-1:0]   i_pstrb,
  output logic [DATA_W-1:0]           o_prdata,
  output logic                        o_pready,
  output logic                        o_pslverr
);

  localparam int                STRB_W    = strb_w(DATA_W);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_write, w_write_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]   r_strb, w_strb_nxt;
  logic                r_err, w_err_nxt;
  logic                r_pready, w_pready_nxt;
  logic                r_pslverr, w_pslverr_nxt;
  logic                r_rd_ok, w_rd_ok_nxt;

  logic                w_addr_err;
  logic                w_mem_ce;
  logic                w_mem_wren;
  logic                w_mem_rden;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_rd_data;

  assign w_addr_err = ({1'b0, i_paddr} >= (ADDR_W+1)'(DEPTH));

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rd_ok   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_write   <= w_write_nxt;
      r_wdata   <= w_wdata_nxt;
      r_strb    <= w_strb_nxt;
      r_err     <= w_err_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_rd_ok   <= w_rd_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_write_nxt   = r_write;
    w_wdata_nxt   = r_wdata;
    w_strb_nxt    = r_strb;
    w_err_nxt     = r_err;
    w_pready_nxt  = r_pready;
    w_pslverr_nxt = r_pslverr;
    w_rd_ok_nxt   = r_rd_ok;
    w_mem_ce      = 1'b0;
    w_mem_wren    = 1'b0;
    w_mem_rden    = 1'b0;
    w_mem_addr    = r_addr;

    case (r_state)
      S_IDLE: begin
        if (i_psel && !i_penable) begin
          w_addr_nxt  = i_paddr;
          w_write_nxt = i_pwrite;
          w_wdata_nxt = i_pwdata;
          w_strb_nxt  = i_pstrb;
          w_err_nxt   = w_addr_err;
          // The RAM output register becomes PRDATA; only a good read exposes it.
          w_rd_ok_nxt = !i_pwrite && !w_addr_err;
          if (!i_pwrite && !w_addr_err) begin
            w_mem_ce   = 1'b1;
            w_mem_rden = 1'b1;
            w_mem_addr = i_paddr;
          end
          if (WAIT == 0) begin
            w_state_nxt   = S_READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_addr_err;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_psel) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt   = S_READY;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = r_err;
          end
        end
      end
      S_READY: begin
        if (!i_psel) begin
          w_state_nxt   = S_IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end else if (i_penable && r_pready) begin
          if (r_write && !r_err) begin
            w_mem_ce   = 1'b1;
            w_mem_wren = 1'b1;
          end
          w_state_nxt   = S_IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
      end
    endcase
  end

  mem_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (i_pclk),
    .i_ce      (w_mem_ce),
    .i_wren    (w_mem_wren),
    .i_rden    (w_mem_rden),
    .i_be      (r_strb),
    .i_addr    (w_mem_addr),
    .i_wr_data (r_wdata),
    .o_rd_data (w_mem_rd_data)
  );

  assign o_prdata  = r_rd_ok ? w_mem_rd_data : '0;
  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem.sv
// tb/tb_apb_mem.sv - self-checking bench for apb_mem against a word-array reference model
module tb_apb_mem;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DEP = 200;
  localparam int NW  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_psel;
  logic            i_penable;
  logic            i_pwrite;
  logic [AW-1:0]   i_paddr;
  logic [DW-1:0]   i_pwdata;
  logic [DW/8-1:0] i_pstrb;
  logic [DW-1:0]   o_prdata;
  logic            o_pready;
  logic            o_pslverr;

  logic [31:0]     model [DEP];
  int              n_cmp = 0;
  int              n_bad = 0;
  int unsigned     cyc = 0;
  int unsigned     last_start = 0;

  apb_mem #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEP),
    .WAIT   (NW)
  ) dut (
    .i_pclk    (clk),
    .i_presetn (rst_n),
    .i_psel    (i_psel),
    .i_penable (i_penable),
    .i_pwrite  (i_pwrite),
    .i_paddr   (i_paddr),
    .i_pwdata  (i_pwdata),
    .i_pstrb   (i_pstrb),
    .o_prdata  (o_prdata),
    .o_pready  (o_pready),
    .o_pslverr (o_pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_psel    = 1'b0;
      i_penable = 1'b0;
    end
  endtask

  // One complete transfer; expectations come from the word-array model.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rd;
    exp_err = (int'(a) >= DEP);
    exp_rd  = (!wr && !exp_err) ? model[a] : 32'h0;
    @(negedge clk);
    i_psel    = 1'b1;
    i_penable = 1'b0;
    i_pwrite  = wr;
    i_paddr   = a;
    i_pwdata  = d;
    i_pstrb   = s;
    last_start = cyc;
    @(negedge clk);
    i_penable = 1'b1;
    waits = 0;
    while (o_pready !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("wait_cycles", 64'(waits), 64'(NW));
    check("pready", 64'(o_pready), 64'd1);
    check("pslverr", 64'(o_pslverr), 64'(exp_err));
    check("prdata", 64'(o_prdata), 64'(exp_rd));
    rd = o_prdata;
    if (wr && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic reset_mid(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] exp_first);
    @(negedge clk);
    i_psel    = 1'b1;
    i_penable = 1'b0;
    i_pwrite  = wr;
    i_paddr   = a;
    i_pwdata  = d;
    i_pstrb   = 4'hF;
    @(negedge clk);
    i_penable = 1'b1;
    check("rst_pre_prdata", 64'(o_prdata), 64'(exp_first));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_prdata", 64'(o_prdata), 64'd0);
    check("rst_async_pready", 64'(o_pready), 64'd0);
    check("rst_async_pslverr", 64'(o_pslverr), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    i_psel    = 1'b0;
    i_penable = 1'b0;
  endtask

  initial begin
    logic [31:0]     rd;
    int unsigned     t0, t1, t2;
    logic            wr;
    logic [7:0]      a;

    rst_n     = 1'b0;
    i_psel    = 1'b0;
    i_penable = 1'b0;
    i_pwrite  = 1'b0;
    i_paddr   = '0;
    i_pwdata  = '0;
    i_pstrb   = '0;
    repeat (3) @(negedge clk);
    check("reset_prdata", 64'(o_prdata), 64'd0);
    check("reset_pready", 64'(o_pready), 64'd0);
    check("reset_pslverr", 64'(o_pslverr), 64'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < DEP; i++) xfer(1'b1, 8'(i), $urandom, 4'hF, rd);

    xfer(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, rd);
    xfer(1'b0, 8'd5, 32'h0, 4'h0, rd);
    check("full_write_read", 64'(rd), 64'hDEADBEEF);
    xfer(1'b1, 8'd5, 32'h000000AA, 4'b0001, rd);
    check("write_clears_prdata", 64'(rd), 64'd0);
    xfer(1'b0, 8'd5, 32'h0, 4'h0, rd);
    check("strb_merge", 64'(rd), 64'hDEADBEAA);
    idle(3);
    check("prdata_hold", 64'(o_prdata), 64'hDEADBEAA);
    check("idle_pready", 64'(o_pready), 64'd0);

    xfer(1'b1, 8'd6, 32'h12345678, 4'h0, rd);
    xfer(1'b0, 8'd6, 32'h0, 4'h0, rd);

    xfer(1'b0, 8'd200, 32'h0, 4'h0, rd);
    check("oor_read_data", 64'(rd), 64'd0);
    xfer(1'b1, 8'd55, 32'h55AA55AA, 4'hF, rd);
    xfer(1'b1, 8'd255, 32'hFFFFFFFF, 4'hF, rd);
    xfer(1'b0, 8'd55, 32'h0, 4'h0, rd);
    check("no_alias", 64'(rd), 64'h55AA55AA);

    xfer(1'b0, 8'd10, 32'h0, 4'h0, rd);
    t0 = last_start;
    xfer(1'b1, 8'd11, $urandom, 4'hF, rd);
    t1 = last_start;
    xfer(1'b0, 8'd11, 32'h0, 4'h0, rd);
    t2 = last_start;
    check("b2b_period_1", 64'(t1 - t0), 64'(NW + 2));
    check("b2b_period_2", 64'(t2 - t1), 64'(NW + 2));

    xfer(1'b1, 8'd7, 32'h00000011, 4'hF, rd);
    idle(1);
    reset_mid(1'b0, 8'd7, 32'h0, 32'h00000011);
    reset_mid(1'b1, 8'd7, 32'h00000022, 32'h0);
    xfer(1'b0, 8'd7, 32'h0, 4'h0, rd);
    check("rst_no_write", 64'(rd), 64'h00000011);

    // Abort: PSEL drops while the write is still counting wait states.
    idle(1);
    @(negedge clk);
    i_psel    = 1'b1;
    i_penable = 1'b0;
    i_pwrite  = 1'b1;
    i_paddr   = 8'd9;
    i_pwdata  = ~model[9];
    i_pstrb   = 4'hF;
    @(negedge clk);
    i_penable = 1'b1;
    @(negedge clk);
    i_psel    = 1'b0;
    i_penable = 1'b0;
    @(negedge clk);
    check("abort_pready", 64'(o_pready), 64'd0);
    check("abort_pslverr", 64'(o_pslverr), 64'd0);
    xfer(1'b0, 8'd9, 32'h0, 4'h0, rd);

    idle(1);
    @(negedge clk);
    i_psel    = 1'b1;
    i_penable = 1'b1;
    i_pwrite  = 1'b1;
    i_paddr   = 8'd3;
    i_pwdata  = ~model[3];
    i_pstrb   = 4'hF;
    repeat (NW + 3) @(negedge clk);
    check("stray_penable_pready", 64'(o_pready), 64'd0);
    idle(1);
    xfer(1'b0, 8'd3, 32'h0, 4'h0, rd);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                       : 8'($urandom_range(0, 199));
      xfer(wr, a, $urandom, 4'($urandom_range(0, 15)), rd);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    for (int i = 0; i < DEP; i += 17) xfer(1'b0, 8'(i), 32'h0, 4'h0, rd);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
